// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// default sizing constants and the data-wait predicate.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        DWAIT = 3'd2,
        HALT  = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 256;

    function automatic logic data_wait(input logic req, input logic rdy);
        return req & ~rdy;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/control bundle between the pipeline hazard sources and the
// sequencer; master drives requests, slave (the sequencer) drives controls.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hz_stall;
    logic             br_taken;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hz_stall, br_taken, imem_ready, dmem_req, dmem_ready, halt_req,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush,
        input  halted, timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  hz_stall, br_taken, imem_ready, dmem_req, dmem_ready, halt_req,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush,
        output halted, timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: clear wins, otherwise increment until all-ones
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: arbitrates stall, redirect, memory-wait and
// halt requests into per-stage enables/bubbles and counts stall/flush cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    // Counter value in the last DWAIT cycle allowed before the timeout; the
    // cycle that detected the wait in RUN is the first frozen cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 2);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic dwait_s;
    logic active_s;
    logic br_win_s;
    logic pc_en_s, ifid_en_s, exmem_en_s;
    logic ifid_flush_s, idex_flush_s, memwb_flush_s;
    logic halted_s, timeout_err_s;

    assign dwait_s = data_wait(bus.dmem_req, bus.dmem_ready);

    // next-state and Mealy control outputs
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        active_s      = 1'b0;
        br_win_s      = 1'b0;
        pc_en_s       = 1'b1;
        ifid_en_s     = 1'b1;
        exmem_en_s    = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        memwb_flush_s = 1'b0;
        halted_s      = 1'b0;
        timeout_err_s = 1'b0;
        case (state_q)
            RUN, DWAIT: begin
                active_s = 1'b1;
                if (dwait_s) begin
                    pc_en_s       = 1'b0;
                    ifid_en_s     = 1'b0;
                    exmem_en_s    = 1'b0;
                    memwb_flush_s = 1'b1;
                    if (state_q == RUN) begin
                        state_d = DWAIT;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ERR;
                    end else begin
                        state_d = DWAIT;
                        wait_d  = wait_q + WAIT_W'(1);
                    end
                end else begin
                    if (bus.hz_stall) begin
                        pc_en_s      = 1'b0;
                        ifid_en_s    = 1'b0;
                        idex_flush_s = 1'b1;
                    end else if (bus.br_taken) begin
                        ifid_flush_s = 1'b1;
                        br_win_s     = 1'b1;
                    end else if (!bus.imem_ready) begin
                        pc_en_s      = 1'b0;
                        ifid_flush_s = 1'b1;
                    end else begin
                        pc_en_s = 1'b1;
                    end
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                pc_en_s    = 1'b0;
                ifid_en_s  = 1'b0;
                exmem_en_s = 1'b0;
                halted_s   = 1'b1;
            end
            ERR: begin
                pc_en_s       = 1'b0;
                ifid_en_s     = 1'b0;
                exmem_en_s    = 1'b0;
                halted_s      = 1'b1;
                timeout_err_s = 1'b1;
            end
            default: begin
                pc_en_s       = 1'b0;
                ifid_en_s     = 1'b0;
                exmem_en_s    = 1'b0;
                ifid_flush_s  = 1'b1;
                idex_flush_s  = 1'b1;
                memwb_flush_s = 1'b1;
                state_d       = RUN;
            end
        endcase
    end

    // state and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (active_s & ~pc_en_s),
        .clear (1'b0),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_win_s),
        .clear (1'b0),
        .count (bus.flush_cnt)
    );

    assign bus.pc_en       = pc_en_s;
    assign bus.ifid_en     = ifid_en_s;
    assign bus.exmem_en    = exmem_en_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_flush  = idex_flush_s;
    assign bus.memwb_flush = memwb_flush_s;
    assign bus.halted      = halted_s;
    assign bus.timeout_err = timeout_err_s;

endmodule
